bitop_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single 4-bit bitwise logic unit (OR / AND / XOR / NOR) between four requesters. Each requester presents two 4-bit operands and an opcode and raises a request. The arbiter grants one requester at a time, latches its operands, and computes the result in a registered stage. It then returns the result with a done pulse and the winner's ID. The block sits between the lab's bitwise operator datapath and the requesting units, so the datapath is instantiated once rather than per requester.

---
 rtl/bitop_arbiter.sv | 124 ++++++++++++
 tb/tb_bitop_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bitop_arbiter.sv
// Round-robin arbiter sharing one registered 4-bit bitwise logic unit
// (OR/AND/XOR/NOR) between four requesters.
module bitop_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] a_bus,
  input  logic [15:0] b_bus,
  input  logic [7:0]  op_bus,
  output logic [3:0]  grant,
  output logic        busy,
  output logic [3:0]  s,
  output logic        done,
  output logic [1:0]  done_id
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 4;
  localparam int unsigned OPW  = 2;
  localparam int unsigned IDW  = 2;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [DW-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic [OPW-1:0] opc_q, opc_d;
  logic [IDW-1:0] id_q, id_d;
  logic [NREQ-1:0] grant_d;
  logic           busy_d, done_d;
  logic [DW-1:0]  s_d, res;
  logic [IDW-1:0] done_id_d;
  logic [IDW-1:0] win;
  logic           found;

  // Shared logic unit, fed only from the latched operands
  always_comb begin
    res = '0;
    case (opc_q)
      2'b00: res = opa_q | opb_q;
      2'b01: res = opa_q & opb_q;
      2'b10: res = opa_q ^ opb_q;
      2'b11: res = ~(opa_q | opb_q);
      default: res = '0;
    endcase
  end

  // First set request searched from ptr upward, wrapping mod 4
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[ptr_q + IDW'(i)]) begin
        found = 1'b1;
        win   = ptr_q + IDW'(i);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    opc_d     = opc_q;
    id_d      = id_q;
    grant_d   = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    s_d       = s;
    done_id_d = done_id;
    case (state_q)
      IDLE: begin
        if (found) begin
          opa_d   = a_bus[{win, 2'b00} +: DW];
          opb_d   = b_bus[{win, 2'b00} +: DW];
          opc_d   = op_bus[{win, 1'b0} +: OPW];
          id_d    = win;
          grant_d = NREQ'(1) << win;
          busy_d  = 1'b1;
          ptr_d   = win + IDW'(1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        s_d       = res;
        done_d    = 1'b1;
        done_id_d = id_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      id_q    <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      s       <= '0;
      done    <= 1'b0;
      done_id <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      id_q    <= id_d;
      grant   <= grant_d;
      busy    <= busy_d;
      s       <= s_d;
      done    <= done_d;
      done_id <= done_id_d;
    end
  end

endmodule

// File: tb/tb_bitop_arbiter.sv
// Scoreboard bench for bitop_arbiter: stimulus queues expected {id, s},
// a negedge monitor pops and compares on every done pulse.
module tb_bitop_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  logic [7:0]  op_bus;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  s;
  logic        done;
  logic [1:0]  done_id;

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];

  bitop_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .op_bus(op_bus), .grant(grant), .busy(busy), .s(s), .done(done),
    .done_id(done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_slice(input int k, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op);
    a_bus[4*k +: 4]  = a;
    b_bus[4*k +: 4]  = b;
    op_bus[2*k +: 2] = op;
  endtask

  // One isolated request from requester k; result checked by the monitor
  task automatic single_op(input int k, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op, input logic [3:0] exp_s);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << k;
    @(negedge clk);
    set_slice(k, a, b, op);
    req = one_hot;
    exp_q.push_back({2'(k), exp_s});
    @(negedge clk);
    check("grant", {4'b0, grant}, {4'b0, one_hot});
    check("busy", {7'b0, busy}, 8'd1);
    req = 4'b0000;
    @(negedge clk);
    check("grant_clr", {4'b0, grant}, 8'd0);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 s=%0h id=%0d expected no done", s, done_id);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        check("done_id", {6'b0, done_id}, {6'b0, e[5:4]});
        check("s", {4'b0, s}, {4'b0, e[3:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with random request and bus activity
    rst    = 1'b1;
    req    = 4'($urandom);
    a_bus  = 16'($urandom);
    b_bus  = 16'($urandom);
    op_bus = 8'($urandom);
    @(negedge clk);
    check("rst_grant", {4'b0, grant}, 8'd0);
    check("rst_busy", {7'b0, busy}, 8'd0);
    check("rst_done", {7'b0, done}, 8'd0);
    check("rst_s", {4'b0, s}, 8'd0);
    check("rst_id", {6'b0, done_id}, 8'd0);
    req = 4'($urandom);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    check("idle_grant", {4'b0, grant}, 8'd0);
    check("idle_busy", {7'b0, busy}, 8'd0);

    // First grant after reset goes to lowest set bit; r2 keeps waiting
    set_slice(1, 4'b0011, 4'b0101, 2'b10);
    set_slice(2, 4'b1111, 4'b0001, 2'b01);
    req = 4'b0110;
    exp_q.push_back({2'd1, 4'b0110});
    exp_q.push_back({2'd2, 4'b0001});
    @(negedge clk);
    check("first_grant", {4'b0, grant}, 8'b0010);
    req = 4'b0100;
    @(negedge clk);
    check("exec_grant", {4'b0, grant}, 8'd0);
    check("exec_busy", {7'b0, busy}, 8'd0);
    @(negedge clk);
    check("second_grant", {4'b0, grant}, 8'b0100);
    req = 4'b0000;
    @(negedge clk);

    // Single request and all opcodes
    single_op(1, 4'b1010, 4'b0101, 2'b00, 4'b1111);
    single_op(0, 4'b1100, 4'b1010, 2'b00, 4'b1110);
    single_op(0, 4'b1100, 4'b1010, 2'b01, 4'b1000);
    single_op(0, 4'b1100, 4'b1010, 2'b10, 4'b0110);
    single_op(0, 4'b1100, 4'b1010, 2'b11, 4'b0001);

    // Operand isolation: bus changes during EXEC are ignored
    @(negedge clk);
    set_slice(2, 4'b1100, 4'b0110, 2'b10);
    req = 4'b0100;
    exp_q.push_back({2'd2, 4'b1010});
    @(negedge clk);
    check("iso_grant", {4'b0, grant}, 8'b0100);
    set_slice(2, 4'b0000, 4'b1111, 2'b11);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);

    // Reset during EXEC: no done, outputs cleared, ptr back to 0
    set_slice(3, 4'b1111, 4'b1111, 2'b00);
    req = 4'b1000;
    @(negedge clk);
    check("abort_grant", {4'b0, grant}, 8'b1000);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    check("abort_done", {7'b0, done}, 8'd0);
    check("abort_s", {4'b0, s}, 8'd0);
    check("abort_busy", {7'b0, busy}, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_done2", {7'b0, done}, 8'd0);

    // Round robin with all four requests held continuously
    set_slice(0, 4'b0001, 4'b0010, 2'b00);
    set_slice(1, 4'b1111, 4'b0101, 2'b01);
    set_slice(2, 4'b1001, 4'b0011, 2'b10);
    set_slice(3, 4'b0100, 4'b0010, 2'b11);
    exp_q.push_back({2'd0, 4'b0011});
    exp_q.push_back({2'd1, 4'b0101});
    exp_q.push_back({2'd2, 4'b1010});
    exp_q.push_back({2'd3, 4'b1001});
    exp_q.push_back({2'd0, 4'b0011});
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] g;
      g = 4'b0001 << (i % 4);
      @(negedge clk);
      check("rr_grant", {4'b0, grant}, {4'b0, g});
      if (i == 4) req = 4'b0000;
      @(negedge clk);
      check("rr_gap", {4'b0, grant}, 8'd0);
    end
    @(negedge clk);
    @(negedge clk);
    check("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
